// File: rtl/dram_device_model.sv
// Single-bank DRAM behavioural model: ACT/PRE/READ/WRITE, CL read pipe, sticky error flag.
// Define DRAM_MODEL_TIMING_CHECK_EN to count the TRCD/TRP windows and raise timing errors.
module dram_device_model #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 6,
  parameter int CL       = 5,
  parameter int TRCD     = 4,
  parameter int TRP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CSn,
  input  logic        RASn,
  input  logic        CASn,
  input  logic [3:0]  WEn,
  input  logic [10:0] A,
  input  logic [31:0] D,
  output logic [31:0] Q,
  output logic        VALID,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE, ACTIVATING, ACTIVE, PRECHARGING
  } st_e;

  st_e st_q, st_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [31:0] mem_q [DEPTH];
  logic [CL-1:0] pv_q;
  logic [31:0] pd_q [CL];
  logic [31:0] q_q;
  logic valid_q, err_q;
  logic [1:0] code_q;

  logic is_act, is_pre, is_rd, is_wr, is_ill;
  logic act_ok, pre_ok, rd_ok, wr_ok;
  logic err_set;
  logic [1:0] err_c;
  logic early_col, early_act;
  logic we_none, we_all;
  logic [AW-1:0] addr;
  logic [31:0] rdata;
  logic unused_a;

  assign we_none  = &WEn;
  assign we_all   = ~|WEn;
  assign addr     = {row_q, A[COL_BITS-1:0]};
  assign rdata    = mem_q[addr];
  assign unused_a = ^A;

`ifdef DRAM_MODEL_TIMING_CHECK_EN
  localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int CW   = $clog2(TMAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign early_col = (st_q == ACTIVATING);
  assign early_act = (st_q == PRECHARGING);
`else
  assign early_col = 1'b0;
  assign early_act = 1'b0;
`endif

  always_comb begin
    is_act = 1'b0;
    is_pre = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    is_ill = 1'b0;
    if (!CSn) begin
      unique case (1'b1)
        (!RASn && CASn && we_none):  is_act = 1'b1;
        (!RASn && CASn && we_all):   is_pre = 1'b1;
        (RASn && !CASn && we_none):  is_rd  = 1'b1;
        (RASn && !CASn && !we_none): is_wr  = 1'b1;
        (RASn && CASn): ;
        default: is_ill = 1'b1;
      endcase
    end
  end

  // Illegal commands are dropped here, so nothing below sees them.
  always_comb begin
    act_ok  = 1'b0;
    pre_ok  = 1'b0;
    rd_ok   = 1'b0;
    wr_ok   = 1'b0;
    err_set = 1'b0;
    err_c   = 2'd0;
    unique case (1'b1)
      is_ill: begin
        err_set = 1'b1;
        err_c   = 2'd3;
      end
      is_act: begin
        if (st_q == IDLE) begin
          act_ok = 1'b1;
        end else begin
          err_set = 1'b1;
          err_c   = early_act ? 2'd2 : 2'd1;
        end
      end
      is_pre: begin
        if (st_q == ACTIVE) begin
          pre_ok = 1'b1;
        end else if (st_q == IDLE) begin
          err_set = 1'b1;
          err_c   = 2'd1;
        end
      end
      (is_rd || is_wr): begin
        if (st_q == ACTIVE) begin
          rd_ok = is_rd;
          wr_ok = is_wr;
        end else begin
          err_set = 1'b1;
          err_c   = early_col ? 2'd2 : 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= IDLE;
      row_q <= '0;
`ifdef DRAM_MODEL_TIMING_CHECK_EN
      cnt_q <= '0;
`endif
    end else begin
      st_q  <= st_d;
      row_q <= row_d;
`ifdef DRAM_MODEL_TIMING_CHECK_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  always_comb begin
    st_d  = st_q;
    row_d = row_q;
`ifdef DRAM_MODEL_TIMING_CHECK_EN
    cnt_d = cnt_q;
`endif
    unique case (st_q)
      IDLE: begin
        if (act_ok) begin
          st_d  = ACTIVATING;
          row_d = A[ROW_BITS-1:0];
`ifdef DRAM_MODEL_TIMING_CHECK_EN
          cnt_d = CW'(TRCD - 1);
`endif
        end
      end
      ACTIVATING: begin
`ifdef DRAM_MODEL_TIMING_CHECK_EN
        if (cnt_q <= CW'(1)) begin
          st_d  = ACTIVE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`else
        st_d = ACTIVE;
`endif
      end
      ACTIVE: begin
        if (pre_ok) begin
          st_d = PRECHARGING;
`ifdef DRAM_MODEL_TIMING_CHECK_EN
          cnt_d = CW'(TRP - 1);
`endif
        end
      end
      PRECHARGING: begin
`ifdef DRAM_MODEL_TIMING_CHECK_EN
        if (cnt_q <= CW'(1)) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`else
        st_d = IDLE;
`endif
      end
    endcase
  end

  always_comb begin
    Q        = q_q;
    VALID    = valid_q;
    err      = err_q;
    err_code = code_q;
  end

  // Array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (!WEn[b]) mem_q[addr][8*b +: 8] <= D[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q    <= '0;
      for (int i = 0; i < CL; i++) pd_q[i] <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      pv_q[0] <= rd_ok;
      pd_q[0] <= rdata;
      for (int i = 1; i < CL; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      valid_q <= pv_q[CL-1];
      if (pv_q[CL-1]) q_q <= pd_q[CL-1];
      if (err_set && !err_q) begin
        err_q  <= 1'b1;
        code_q <= err_c;
      end
    end
  end
endmodule

// File: doc/dram_device_model.md
DRAM_DEVICE_MODEL -- requirements
Module: dram_device_model

Interface
REQ-001 The block SHALL have parameter ROW_BITS, default 4, meaning row-address bits taken from A[ROW_BITS-1:0] at ACT.
REQ-002 The block SHALL have parameter COL_BITS, default 6, meaning column-address bits taken from A[COL_BITS-1:0] at READ/WRITE; array depth = 2^(ROW_BITS+COL_BITS) 32-bit words.
REQ-003 The block SHALL have parameter CL, default 5, range 1-5, meaning CAS latency in clk cycles.
REQ-004 The block SHALL have parameter TRCD, default 4, meaning minimum cycles from ACT to READ/WRITE.
REQ-005 The block SHALL have parameter TRP, default 4, meaning minimum cycles from PRE to the next ACT.
REQ-006 The block SHALL have port clk, input, 1 bit, the clock; all sampling is on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, reset (asynchronous, active-low).
REQ-008 The block SHALL have port CSn, input, 1 bit, chip select, active-low; CSn=1 means the cycle is a NOP.
REQ-009 The block SHALL have port RASn, input, 1 bit, row strobe, active-low.
REQ-010 The block SHALL have port CASn, input, 1 bit, column strobe, active-low.
REQ-011 The block SHALL have port WEn, input, 4 bits, per-byte write enables, active-low; bit i covers D[8i+7:8i].
REQ-012 The block SHALL have port A, input, 11 bits, multiplexed row/column address.
REQ-013 The block SHALL have port D, input, 32 bits, write data.
REQ-014 The block SHALL have port Q, output, 32 bits, read data.
REQ-015 The block SHALL have port VALID, output, 1 bit; it pulses high for one cycle per read return.
REQ-016 The block SHALL have port err, output, 1 bit, sticky protocol-error flag.
REQ-017 The block SHALL have port err_code, output, 2 bits, cause of the first error: 1=illegal state, 2=timing, 3=illegal encoding.

Function
REQ-018 The block SHALL decode commands only when CSn=0, as follows: ACT = RASn=0, CASn=1, WEn=1111; PRE = RASn=0, CASn=1, WEn=0000; READ = RASn=1, CASn=0, WEn=1111; WRITE = RASn=1, CASn=0, WEn!=1111; NOP = RASn=1, CASn=1; every other encoding is illegal.
REQ-019 The block SHALL keep a bank FSM with states IDLE, ACTIVATING, ACTIVE, PRECHARGING.
REQ-020 The bank FSM SHALL make these transitions: IDLE -ACT-> ACTIVATING (latch row); ACTIVATING -> ACTIVE after TRCD cycles; ACTIVE -PRE-> PRECHARGING; PRECHARGING -> IDLE after TRP cycles.
REQ-021 A READ in ACTIVE SHALL put mem[{row,col}] into a CL-deep return pipeline; Q gets that word and VALID=1 exactly CL cycles after the command edge.
REQ-022 READs SHALL be accepted on consecutive cycles, each returning in order, with one VALID pulse per READ.
REQ-023 A WRITE in ACTIVE SHALL update the bytes whose WEn bit is 0 at the command edge; other bytes SHALL be unchanged.
REQ-024 A READ to the same address one or more cycles after a WRITE SHALL return the new data.
REQ-025 Q SHALL hold the last returned word while VALID=0.
REQ-026 When a command is illegal in the current state (ACT not in IDLE; READ/WRITE not in ACTIVE; PRE in IDLE), the block SHALL ignore it, leave the FSM and array unchanged, and raise error code 1.
REQ-027 A command with an illegal encoding SHALL be ignored and SHALL raise error code 3.
REQ-028 err SHALL be sticky until reset; err_code SHALL record only the first error.
REQ-029 A PRE issued while reads are pending in the pipeline SHALL still let those reads return on schedule.

Reset
REQ-030 While rst=0 the block SHALL force: FSM=IDLE, timing counters=0, return pipeline flushed, VALID=0, Q=0, err=0, err_code=0.
REQ-031 The array contents SHALL NOT be cleared by reset.
REQ-032 When rst is asserted mid-operation, pending reads SHALL be discarded and SHALL never produce VALID.

Configuration
REQ-033 With DRAM_MODEL_TIMING_CHECK_EN defined, the block SHALL count the TRCD and TRP windows; a READ/WRITE during ACTIVATING, or an ACT during PRECHARGING, SHALL be ignored and SHALL raise error code 2.
REQ-034 Without DRAM_MODEL_TIMING_CHECK_EN, ACTIVATING and PRECHARGING SHALL last exactly one cycle, no code-2 errors SHALL be raised, and the timing counters SHALL be absent.

Verification
REQ-035 Scenario: ACT A=3; wait 4 cycles; WRITE A=5, D=0xDEADBEEF, WEn=0000; READ A=5 -> VALID exactly 5 cycles after the READ edge, Q=0xDEADBEEF.
REQ-036 Scenario: following REQ-035, WRITE A=5, D=0x11223344, WEn=1110; READ A=5 -> Q=0xDEADBE44.
REQ-037 Scenario: four back-to-back READs of columns 0-3 holding 0xA0-0xA3 -> four consecutive VALID pulses, Q=0xA0, 0xA1, 0xA2, 0xA3 in order.
REQ-038 Scenario: READ issued in IDLE -> no VALID; err=1, err_code=1; a later timing error leaves err_code=1.
REQ-039 Scenario (macro defined): ACT then READ 2 cycles later -> READ ignored, err_code=2; with the macro undefined, the same sequence returns data with no error.
REQ-040 Scenario: READ issued, then rst pulsed low 2 cycles later -> no VALID for 10 cycles after reset release; previously written data is still readable.
